// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch stage: owns the PC, fetches over a ready/valid
// memory port, holds one instruction for decode and squashes fetches made stale by redirects.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [6:0]  inst_opcode,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misaligned
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] inst_q, inst_pc_q;
  logic        capture;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      inst_q           <= NOP_INST;
      inst_pc_q        <= 32'h0;
      fetch_misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (capture) begin
        inst_q    <= imem_rdata;
        inst_pc_q <= pc;
      end
      if (redirect_valid && (redirect_pc[1:0] != 2'b00))
        fetch_misaligned <= 1'b1;
    end
  end

  // Redirect wins over everything but reset; a request already accepted must be drained.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    pc_nxt    = pc;
    case (state)
      IDLE:  state_nxt = REQ;
      REQ:   if (imem_ready) state_nxt = redirect_valid ? DRAIN : WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) state_nxt = REQ;
          else begin
            state_nxt = HOLD;
            capture   = 1'b1;
          end
        end else if (redirect_valid) begin
          state_nxt = DRAIN;
        end
      end
      HOLD:  if (redirect_valid || inst_ready) state_nxt = REQ;
      // The stale response still has to be swallowed even if another redirect lands.
      DRAIN: if (imem_rvalid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (redirect_valid)
      pc_nxt = {redirect_pc[31:2], 2'b00};
    else if (capture)
      pc_nxt = pc + 32'd4;
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign inst_valid  = (state == HOLD);
  assign inst        = inst_valid ? inst_q : NOP_INST;
  assign inst_opcode = inst[6:0];
  assign inst_pc     = inst_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a reactive memory model plus scoreboard queues of
// expected fetch addresses and consumed instructions, checked by independent monitors.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready, redirect_valid, fetch_misaligned;
  logic [31:0] inst, inst_pc, redirect_pc;
  logic [6:0]  inst_opcode;

  // second instance with a top-of-memory reset PC, always ready/consuming
  logic        hi_req, hi_rvalid, hi_prev, hi_iv, hi_mis;
  logic [31:0] hi_addr, hi_inst, hi_pc;
  logic [6:0]  hi_op;
  int          hi_n;

  int errs = 0, checks = 0;
  int rv_delay;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_inst_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_opcode(inst_opcode), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_misaligned(fetch_misaligned)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk(clk), .rst(rst), .imem_req(hi_req), .imem_addr(hi_addr),
    .imem_ready(1'b1), .imem_rvalid(hi_rvalid), .imem_rdata(32'h0000_0013),
    .inst_valid(hi_iv), .inst(hi_inst), .inst_opcode(hi_op), .inst_pc(hi_pc),
    .inst_ready(1'b1), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .fetch_misaligned(hi_mis)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] addr, input logic [31:0] word);
    exp_addr_q.push_back(addr);
    exp_inst_q.push_back({word, addr});
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h4) ? 32'h0050_0093 : {a[23:0], 8'h33};
  endfunction

  // memory: one response rv_delay cycles after each accepted request
  initial begin
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0; cnt = 0; paddr = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end
      end
      if (!rst && imem_req && imem_ready) begin
        pend = 1'b1; cnt = rv_delay; paddr = imem_addr;
      end
    end
  end

  // request monitor
  initial forever begin
    @(negedge clk);
    if (!rst && imem_req && imem_ready) begin
      if (exp_addr_q.size() == 0) chk("unexpected_req", imem_addr, 32'hxxxx_xxxx);
      else chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
    end
  end

  // consumption monitor
  initial forever begin
    logic [63:0] e;
    @(negedge clk);
    if (!rst && inst_valid && inst_ready) begin
      if (exp_inst_q.size() == 0) chk("unexpected_inst", inst, 32'hxxxx_xxxx);
      else begin
        e = exp_inst_q.pop_front();
        chk("inst", inst, e[63:32]);
        chk("inst_pc", inst_pc, e[31:0]);
        chk("inst_opcode", {25'h0, inst_opcode}, {25'h0, e[38:32]});
      end
    end
  end

  // high-reset-PC instance: rvalid one cycle after accept, first two addresses checked
  initial begin
    hi_rvalid = 1'b0; hi_prev = 1'b0; hi_n = 0;
    forever begin
      @(negedge clk);
      hi_rvalid = hi_prev;
      hi_prev   = hi_req && !rst;
      if (!rst && hi_req && hi_n < 2) begin
        chk("hi_fetch_addr", hi_addr, (hi_n == 0) ? 32'hFFFF_FFFC : 32'h0000_0000);
        hi_n++;
      end
    end
  end

  task automatic chk_reset_state();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_misaligned", {31'h0, fetch_misaligned}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b1; inst_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; rv_delay = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    rst = 1'b0;
    // c1 idle; sequential fetch 0,4,8
    push(32'h0, 32'h0000_0033);
    push(32'h4, 32'h0050_0093);
    push(32'h8, 32'h0000_0833);
    tick();                                         // c2
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    repeat (9) tick();                              // c11, REQ for 0xC
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", {31'h0, imem_req}, 32'h1);
      chk("stall_addr", imem_addr, 32'hC);
      tick();
    end
    // c14: accept, then hold the instruction with inst_ready low
    imem_ready = 1'b1; inst_ready = 1'b0;
    push(32'hC, 32'h0000_0C33);
    tick(); imem_ready = 1'b0;                      // c15 WAIT
    tick();                                         // c16 HOLD
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'h0, inst_valid}, 32'h1);
      chk("hold_inst", inst, 32'h0000_0C33);
      chk("hold_pc", inst_pc, 32'hC);
      chk("hold_no_req", {31'h0, imem_req}, 32'h0);
      tick();
    end
    inst_ready = 1'b1;                              // c21 consumed
    tick();                                         // c22
    chk("req_after_consume", {31'h0, imem_req}, 32'h1);
    chk("addr_after_consume", imem_addr, 32'h10);
    // redirect while waiting; stale response lands two cycles after redirect
    imem_ready = 1'b1; rv_delay = 3;
    exp_addr_q.push_back(32'h10);
    tick(); imem_ready = 1'b0;                      // c23 WAIT
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(); redirect_valid = 1'b0;                  // c24 DRAIN
    for (int i = 0; i < 2; i++) begin
      chk("drain_no_valid", {31'h0, inst_valid}, 32'h0);
      chk("drain_no_req", {31'h0, imem_req}, 32'h0);
      tick();
    end
    chk("redir_req", {31'h0, imem_req}, 32'h1);     // c26
    chk("redir_addr", imem_addr, 32'h100);
    imem_ready = 1'b1; rv_delay = 1;
    push(32'h100, 32'h0001_0033);
    tick(); imem_ready = 1'b0;                      // c27
    tick(); tick();                                 // c29 REQ 0x104
    chk("seq_addr", imem_addr, 32'h104);
    // misaligned redirect while holding with inst_ready high
    imem_ready = 1'b1;
    push(32'h104, 32'h0001_0433);
    tick(); imem_ready = 1'b0;                      // c30
    tick();                                         // c31 HOLD
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    tick(); redirect_valid = 1'b0;                  // c32
    chk("misaligned_set", {31'h0, fetch_misaligned}, 32'h1);
    chk("misaligned_addr", imem_addr, 32'h200);
    chk("misaligned_req", {31'h0, imem_req}, 32'h1);
    chk("misaligned_no_valid", {31'h0, inst_valid}, 32'h0);
    imem_ready = 1'b1;
    push(32'h200, 32'h0002_0033);
    tick(); imem_ready = 1'b0;                      // c33
    tick(); tick();                                 // c35 REQ 0x204
    chk("misaligned_sticky", {31'h0, fetch_misaligned}, 32'h1);
    chk("after_misaligned_addr", imem_addr, 32'h204);
    // PC wrap from the top of memory
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); redirect_valid = 1'b0;                  // c36
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    push(32'hFFFF_FFFC, 32'hFFFF_FC33);
    tick(); imem_ready = 1'b0;                      // c37
    tick(); tick();                                 // c39
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", {31'h0, imem_req}, 32'h1);
    // reset during WAIT, late response must be ignored
    imem_ready = 1'b1; rv_delay = 3;
    exp_addr_q.push_back(32'h0);
    tick(); imem_ready = 1'b0; rst = 1'b1;          // c40 WAIT
    tick();                                         // c41 IDLE
    chk_reset_state();
    rst = 1'b0;
    tick();                                         // c42 REQ, stale rvalid arrives
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", {31'h0, imem_req}, 32'h1);
    tick();                                         // c43
    chk("late_rvalid_ignored", {31'h0, inst_valid}, 32'h0);
    chk("still_req", {31'h0, imem_req}, 32'h1);
    imem_ready = 1'b1; rv_delay = 1;
    push(32'h0, 32'h0000_0033);
    tick(); imem_ready = 1'b0;                      // c44
    repeat (4) tick();
    chk("addr_queue_drained", exp_addr_q.size(), 32'h0);
    chk("inst_queue_drained", exp_inst_q.size(), 32'h0);
    chk("hi_addrs_seen", hi_n, 32'h2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
